// File: rtl/alu_op_decoder_pkg.sv
// Shared payload types: common::s_shift (shift field) and alu::s_config (ALU op bundle).
package common;

    typedef struct packed {
        logic       arith;
        logic [4:0] amount;
    } s_shift;

endpackage

package alu;

    typedef enum logic [3:0] {
        CORE_ADD = 4'd0,
        CORE_AND = 4'd1,
        CORE_XOR = 4'd2,
        CORE_SHL = 4'd3,
        CORE_SHR = 4'd4,
        CORE_ASL = 4'd5,
        CORE_ASR = 4'd6,
        CORE_ROL = 4'd7,
        CORE_ROR = 4'd8
    } e_core_op;

    typedef enum logic [1:0] {
        UN_ID  = 2'd0,
        UN_NOT = 2'd1,
        UN_NEG = 2'd2
    } e_unary;

    typedef struct packed {
        e_core_op      op;
        e_unary        a_op;
        e_unary        b_op;
        e_unary        out_op;
        common::s_shift b_shift;
    } s_config;

endpackage

// File: rtl/alu_op_decoder_if.sv
// Issue-side and ALU-side handshake bundle of the opcode decoder.
interface alu_op_decoder_if #(
    parameter int unsigned TAG_W = 4
);
    localparam int unsigned SHIFT_W = $bits(common::s_shift);

    logic               in_valid;
    logic               in_ready;
    logic [4:0]         in_opcode;
    logic [SHIFT_W-1:0] in_shift;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    alu::s_config       out_cfg;
    logic [TAG_W-1:0]   out_tag;
    logic               out_illegal;

    // Environment side: issues ops and consumes decoded configs
    modport master (
        output in_valid, in_opcode, in_shift, in_tag, out_ready,
        input  in_ready, out_valid, out_cfg, out_tag, out_illegal
    );

    // Decoder side
    modport slave (
        input  in_valid, in_opcode, in_shift, in_tag, out_ready,
        output in_ready, out_valid, out_cfg, out_tag, out_illegal
    );
endinterface

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: decodes opcode + shift field into alu::s_config with a
// 1-cycle latency and a 2-entry skid buffer (main + skid) so in_ready is a flop.
// Optional feature macro: ALU_DEC_ILLEGAL_CNT_EN (saturating illegal-op counter).
module alu_op_decoder #(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_op_decoder_if.slave      bus,
    output logic [CNT_W-1:0]     illegal_cnt
);

    typedef struct packed {
        alu::s_config     cfg;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e state_q;
    state_e state_nxt;
    entry_t dec;
    entry_t main_q;
    entry_t skid_q;
    logic   in_ready_q;
    logic   out_valid_q;
    logic   accept;
    logic   xfer;
    logic   load_main_in;
    logic   load_main_skid;
    logic   load_skid;

    assign accept = bus.in_valid && in_ready_q;
    assign xfer   = out_valid_q && bus.out_ready;

    // Decode the incoming op; derived ops are core ops plus unary modifiers
    always_comb begin
        dec              = '0;
        dec.cfg.op       = alu::CORE_ADD;
        dec.cfg.a_op     = alu::UN_ID;
        dec.cfg.b_op     = alu::UN_ID;
        dec.cfg.out_op   = alu::UN_ID;
        dec.cfg.b_shift  = common::s_shift'(bus.in_shift);
        dec.tag          = bus.in_tag;
        dec.illegal      = 1'b0;
        case (bus.in_opcode)
            5'd0:  dec.cfg.op = alu::CORE_ADD;
            5'd1:  begin dec.cfg.op = alu::CORE_ADD; dec.cfg.b_op = alu::UN_NEG; end
            5'd2:  begin dec.cfg.op = alu::CORE_ADD; dec.cfg.a_op = alu::UN_NEG; end
            5'd3:  dec.cfg.op = alu::CORE_AND;
            5'd4:  begin
                dec.cfg.op     = alu::CORE_AND;
                dec.cfg.a_op   = alu::UN_NOT;
                dec.cfg.b_op   = alu::UN_NOT;
                dec.cfg.out_op = alu::UN_NOT;
            end
            5'd5:  dec.cfg.op = alu::CORE_XOR;
            5'd6:  begin dec.cfg.op = alu::CORE_XOR; dec.cfg.out_op = alu::UN_NOT; end
            5'd7:  begin dec.cfg.op = alu::CORE_AND; dec.cfg.out_op = alu::UN_NOT; end
            5'd8:  begin
                dec.cfg.op   = alu::CORE_AND;
                dec.cfg.a_op = alu::UN_NOT;
                dec.cfg.b_op = alu::UN_NOT;
            end
            5'd9:  begin dec.cfg.op = alu::CORE_AND; dec.cfg.b_op = alu::UN_NOT; end
            5'd10: dec.cfg.op = alu::CORE_SHL;
            5'd11: dec.cfg.op = alu::CORE_SHR;
            5'd12: dec.cfg.op = alu::CORE_ASL;
            5'd13: dec.cfg.op = alu::CORE_ASR;
            5'd14: dec.cfg.op = alu::CORE_ROL;
            5'd15: dec.cfg.op = alu::CORE_ROR;
            default: dec.illegal = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state: occupancy of main/skid entries
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_nxt = ST_ONE;
            ST_ONE: begin
                if (accept && !xfer)      state_nxt = ST_TWO;
                else if (!accept && xfer) state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (xfer) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Datapath load controls for the current state
    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: load_main_in = accept;
            ST_ONE: begin
                load_main_in = accept && xfer;
                load_skid    = accept && !xfer;
            end
            ST_TWO:   load_main_skid = xfer;
            default: ;
        endcase
    end

    // Entry storage and registered handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_q <= dec;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
            in_ready_q  <= (state_nxt != ST_TWO);
            out_valid_q <= (state_nxt != ST_EMPTY);
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_cfg     = main_q.cfg;
    assign bus.out_tag     = main_q.tag;
    assign bus.out_illegal = main_q.illegal;

`ifdef ALU_DEC_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of accepted illegal ops
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept && dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign illegal_cnt = cnt_q;
`else
    assign illegal_cnt = '0;
`endif

endmodule
